// File: rtl/stm_register_list_reader.sv
// Store-multiple register walker: reads each listed register and issues one memory store per register.
// Optional build macro STM_PC_OFFSET_EN: R15 is stored as read value + PC_STORE_OFFSET.
module stm_register_list_reader #(
  parameter int BUS_WIDTH       = 32,
  parameter int PC_STORE_OFFSET = 12
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 start_in,
  input  logic [15:0]          reg_list_in,
  input  logic [BUS_WIDTH-1:0] base_addr_in,
  input  logic                 up_in,
  input  logic                 pre_in,
  output logic [3:0]           rf_rd_addr_out,
  input  logic [BUS_WIDTH-1:0] rf_rd_data_in,
  output logic [BUS_WIDTH-1:0] mem_addr_out,
  output logic [BUS_WIDTH-1:0] mem_data_out,
  output logic                 mem_wr_en_out,
  input  logic                 mem_ready_in,
  output logic [BUS_WIDTH-1:0] wb_addr_out,
  output logic                 busy_out,
  output logic                 done_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [BUS_WIDTH-1:0] WORD_BYTES = {{(BUS_WIDTH-3){1'b0}}, 3'd4};
  localparam logic [BUS_WIDTH-1:0] PC_ADJ     = BUS_WIDTH'(PC_STORE_OFFSET);

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  state_t               state_r;
  state_t               state_s;
  logic [15:0]          list_r;
  logic [15:0]          list_s;
  logic [BUS_WIDTH-1:0] next_addr_r;
  logic [BUS_WIDTH-1:0] wb_pend_r;
  logic [3:0]           rf_rd_addr_r;
  logic [BUS_WIDTH-1:0] mem_addr_r;
  logic [BUS_WIDTH-1:0] mem_data_r;
  logic                 mem_wr_en_r;
  logic [BUS_WIDTH-1:0] wb_addr_r;
  logic                 busy_r;
  logic                 done_r;

  logic [4:0]           count_in_s;
  logic [BUS_WIDTH-1:0] span_s;
  logic [BUS_WIDTH-1:0] start_addr_s;
  logic [BUS_WIDTH-1:0] wb_in_s;
  logic                 pc_sel_s;
  logic [BUS_WIDTH-1:0] store_data_s;

  // Transfer geometry from the start-time inputs; the lowest register always lands at the lowest address.
  always_comb begin
    count_in_s = popcount16(reg_list_in);
    span_s     = {{(BUS_WIDTH-7){1'b0}}, count_in_s, 2'b00};
    wb_in_s    = up_in ? (base_addr_in + span_s) : (base_addr_in - span_s);
    case ({up_in, pre_in})
      2'b10:   start_addr_s = base_addr_in;
      2'b11:   start_addr_s = base_addr_in + WORD_BYTES;
      2'b00:   start_addr_s = base_addr_in - span_s + WORD_BYTES;
      2'b01:   start_addr_s = base_addr_in - span_s;
      default: start_addr_s = base_addr_in;
    endcase
  end

  // Store data, with the optional pipeline offset applied to R15.
  always_comb begin
`ifdef STM_PC_OFFSET_EN
    pc_sel_s = (rf_rd_addr_r == 4'd15);
`else
    pc_sel_s = 1'b0;
`endif
    if (pc_sel_s) begin
      store_data_s = rf_rd_data_in + PC_ADJ;
    end else begin
      store_data_s = rf_rd_data_in;
    end
  end

  // Next-state and remaining-list logic.
  always_comb begin
    state_s = state_r;
    list_s  = list_r;
    case (state_r)
      ST_IDLE: begin
        if (start_in) begin
          list_s  = reg_list_in;
          state_s = (count_in_s == 5'd0) ? ST_DONE : ST_READ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: state_s = ST_WRITE;
      ST_WRITE: begin
        if (mem_ready_in) begin
          list_s  = list_r & ~(16'd1 << rf_rd_addr_r);
          state_s = (list_s != 16'd0) ? ST_READ : ST_DONE;
        end else begin
          state_s = ST_WRITE;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, captured transfer context and registered outputs.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_r      <= ST_IDLE;
      list_r       <= 16'd0;
      next_addr_r  <= '0;
      wb_pend_r    <= '0;
      rf_rd_addr_r <= 4'd0;
      mem_addr_r   <= '0;
      mem_data_r   <= '0;
      mem_wr_en_r  <= 1'b0;
      wb_addr_r    <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      list_r       <= list_s;
      rf_rd_addr_r <= lowest_set(list_s);
      mem_wr_en_r  <= (state_s == ST_WRITE);
      busy_r       <= (state_s != ST_IDLE);
      done_r       <= (state_s == ST_DONE);
      if (state_s == ST_DONE) begin
        wb_addr_r <= (state_r == ST_IDLE) ? wb_in_s : wb_pend_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (start_in) begin
            wb_pend_r   <= wb_in_s;
            next_addr_r <= start_addr_s;
          end
        end
        ST_READ: begin
          // Address and data only change on entry to WRITE, so they hold elsewhere.
          mem_addr_r <= next_addr_r;
          mem_data_r <= store_data_s;
        end
        ST_WRITE: begin
          if (mem_ready_in) begin
            next_addr_r <= next_addr_r + WORD_BYTES;
          end
        end
        ST_DONE: begin
          wb_pend_r <= wb_pend_r;
        end
        default: begin
          wb_pend_r <= wb_pend_r;
        end
      endcase
    end
  end

  assign rf_rd_addr_out = rf_rd_addr_r;
  assign mem_addr_out   = mem_addr_r;
  assign mem_data_out   = mem_data_r;
  assign mem_wr_en_out  = mem_wr_en_r;
  assign wb_addr_out    = wb_addr_r;
  assign busy_out       = busy_r;
  assign done_out       = done_r;

endmodule
